// File: rtl/step_ctrl_pkg.sv
// step_ctrl_pkg: shared types for the STEP/STEP_ACK initiator.
// Controller states, default phase timeout, handshake phase decode.
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2,
    ERR  = 2'd3
  } state_e;

  localparam logic [15:0] TO_CYC_DEF = 16'd1000;

  // Wire-level view of one four-phase handshake.
  typedef enum logic [1:0] {
    PH_OPEN = 2'd0,
    PH_REQ  = 2'd1,
    PH_ACK  = 2'd2,
    PH_REL  = 2'd3
  } hs_phase_e;

  function automatic hs_phase_e hs_phase(
    input logic step,
    input logic ack
  );
    hs_phase_e ph;
    unique case ({step, ack})
      2'b00:   ph = PH_OPEN;
      2'b10:   ph = PH_REQ;
      2'b11:   ph = PH_ACK;
      default: ph = PH_REL;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/step_ctrl_if.sv
// step_ctrl_if: core-side stepping pins (step_mode/step/step_ack/core_done).
// master = step_ctrl, slave = core; phase is a decoded view for monitors.
interface step_ctrl_if;
  import step_ctrl_pkg::*;

  logic      step_mode;
  logic      step;
  logic      step_ack;
  logic      core_done;
  hs_phase_e phase;

  assign phase = hs_phase(step, step_ack);

  modport master (
    output step_mode,
    output step,
    input  step_ack,
    input  core_done
  );

  modport slave (
    input  step_mode,
    input  step,
    output step_ack,
    output core_done
  );
endinterface

// File: rtl/step_phase_timer.sv
// step_phase_timer: clearable saturating cycle counter, hit on limit.
// Ports: clr/en control, limit (0 = never), cnt value, hit flag.
module step_phase_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         hit
);

  logic [W-1:0] nxt;

  assign nxt = cnt + W'(1);

  // hit marks the cycle whose count would reach limit.
  assign hit = en && (limit != '0) && (nxt == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= nxt;
    end
  end

endmodule

// File: rtl/step_ctrl.sv
// step_ctrl: STEP/STEP_ACK initiator; single, burst, abort, timeout.
// Ports: host cmds in, core pins via step_ctrl_if.master, status out.
// Option STEP_CTRL_PERF_EN adds ack_lat_max (longest REQ phase).
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int              CNT_W  = 32,
  parameter int              TO_W   = 16,
  parameter logic [TO_W-1:0] TO_CYC = TO_W'(TO_CYC_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cmd_single,
  input  logic             cmd_burst,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             cmd_abort,
  input  logic             clr_err,
  step_ctrl_if.master      core,
  output logic             ctrl_busy,
  output logic             burst_done,
  output logic             done_seen,
  output logic [CNT_W-1:0] step_count,
  output logic             err_timeout
`ifdef STEP_CTRL_PERF_EN
  ,
  output logic [TO_W-1:0]  ack_lat_max
`endif
);

  state_e           state_q, state_n;
  logic [CNT_W-1:0] rem_q, rem_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             abort_q, abort_n;
  logic             clr_q, clr_n;
  logic             seen_q, seen_n;
  logic             err_q, err_n;
  logic             bd_n, bd_q;
  logic             step_q;
  logic             abort_p;
  logic             in_hs;
  logic             to_hit;
  logic [TO_W-1:0]  ph_cnt;

  assign in_hs   = (state_q == REQ) || (state_q == REL);
  assign abort_p = abort_q || cmd_abort;

  step_phase_timer #(
    .W (TO_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_n != state_q),
    .en    (in_hs),
    .limit (TO_CYC),
    .cnt   (ph_cnt),
    .hit   (to_hit)
  );

  always_comb begin
    state_n = state_q;
    rem_n   = rem_q;
    cnt_n   = cnt_q;
    abort_n = abort_q;
    clr_n   = clr_q;
    seen_n  = seen_q;
    err_n   = err_q;
    bd_n    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && cmd_burst) begin
          seen_n  = 1'b0;
          abort_n = 1'b0;
          if (burst_len != '0) begin
            rem_n   = burst_len;
            state_n = REQ;
          end else begin
            bd_n = 1'b1;
          end
        end else if (enable && cmd_single) begin
          seen_n  = 1'b0;
          abort_n = 1'b0;
          rem_n   = CNT_W'(1);
          state_n = REQ;
        end
      end
      REQ: begin
        abort_n = abort_p;
        // Ack wins over a timeout landing in the same cycle.
        if (core.step_ack) begin
          state_n = REL;
        end else if (to_hit) begin
          state_n = ERR;
        end
      end
      REL: begin
        abort_n = abort_p;
        if (!core.step_ack) begin
          cnt_n = cnt_q + CNT_W'(1);
          rem_n = rem_q - CNT_W'(1);
          if ((rem_q == CNT_W'(1)) || abort_p ||
              core.core_done || !enable) begin
            state_n = IDLE;
            bd_n    = 1'b1;
            seen_n  = core.core_done;
            abort_n = 1'b0;
          end else begin
            state_n = REQ;
          end
        end else if (to_hit) begin
          state_n = ERR;
        end
      end
      ERR: begin
        // Remember a clear while the core still holds ack high.
        if (clr_err) begin
          clr_n = 1'b1;
        end
        if ((clr_err || clr_q) && !core.step_ack) begin
          state_n = IDLE;
          clr_n   = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (clr_err) begin
      err_n = 1'b0;
    end
    if ((state_n == ERR) && (state_q != ERR)) begin
      err_n   = 1'b1;
      abort_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      clr_q   <= 1'b0;
      seen_q  <= 1'b0;
      err_q   <= 1'b0;
      bd_q    <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      rem_q   <= rem_n;
      cnt_q   <= cnt_n;
      abort_q <= abort_n;
      clr_q   <= clr_n;
      seen_q  <= seen_n;
      err_q   <= err_n;
      bd_q    <= bd_n;
      step_q  <= (state_n == REQ);
    end
  end

  assign core.step_mode = enable;
  assign core.step      = step_q;
  assign ctrl_busy      = in_hs;
  assign burst_done     = bd_q;
  assign done_seen      = seen_q;
  assign step_count     = cnt_q;
  assign err_timeout    = err_q;

`ifdef STEP_CTRL_PERF_EN
  logic [TO_W-1:0] lat_q;
  logic [TO_W-1:0] req_len;

  // Cycles spent in REQ, counted at the cycle REQ is left.
  assign req_len = ph_cnt + TO_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_q <= '0;
    end else if (clr_err) begin
      lat_q <= '0;
    end else if ((state_q == REQ) && (state_n != REQ) &&
                 (req_len > lat_q)) begin
      lat_q <= req_len;
    end
  end

  assign ack_lat_max = lat_q;
`endif

endmodule

// File: doc/step_ctrl.md
Name: step_ctrl

Overview:
- Initiator side of the STEP / STEP_ACK four-phase stepping handshake exposed by bilinear_core_scalar.
- Turns host commands (single step, N-step burst, abort) into legal step request/release sequences.
- Counts completed steps, ends bursts early on core done, flags a stuck core by timeout.
- Sits between the host/register block and the core's step_mode/step/step_ack pins; replaces bench-driven stepping.

Parameters:
- CNT_W, 32, width of burst_len and step_count.
- TO_W, 16, width of the per-phase timeout counter.
- TO_CYC, 16'd1000, cycles allowed per handshake phase before timeout; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  stepping enabled; drives step_mode directly
- cmd_single  in  1  one-cycle pulse: issue one step
- cmd_burst  in  1  one-cycle pulse: issue burst_len steps
- burst_len  in  CNT_W  step count for cmd_burst, sampled with it
- cmd_abort  in  1  one-cycle pulse: stop after the current handshake
- clr_err  in  1  pulse: clear err_timeout, leave ERR
- core_done  in  1  core done flag
- step_ack  in  1  core acknowledge
- step_mode  out  1  to core
- step  out  1  registered request to core
- ctrl_busy  out  1  high in REQ/REL
- burst_done  out  1  one-cycle pulse when a command finishes
- done_seen  out  1  burst ended because core_done was high
- step_count  out  CNT_W  total completed handshakes, wraps modulo 2^CNT_W
- err_timeout  out  1  sticky timeout flag

Behaviour:
- Reset values: all outputs 0, state IDLE, internal counters 0.
- States: IDLE, REQ (step=1, wait step_ack=1), REL (step=0, wait step_ack=0), ERR.
- IDLE:
  - With enable=1, a cmd_single sets remaining=1 and moves to REQ; step reads 1 on the next cycle.
  - With enable=1, a cmd_burst with burst_len>0 sets remaining=burst_len and moves to REQ.
  - cmd_burst with burst_len=0 issues no step; burst_done pulses the next cycle.
  - If both commands arrive together, cmd_burst wins.
  - Commands with enable=0 are ignored.
- REQ: step_ack=1 sampled moves to REL and step drops on the next cycle. step is never withdrawn before ack.
- REL, step_ack=0 sampled completes the handshake:
  - step_count and remaining update in the same edge: step_count+1, remaining-1.
  - If remaining becomes 0, abort is pending, core_done=1, or enable=0: go to IDLE, pulse burst_done, and set done_seen=core_done.
  - Otherwise go back to REQ. Minimum of 4 cycles per step with an immediately acking core.
- Commands arriving in REQ/REL/ERR are ignored.
- cmd_abort in REQ/REL latches an abort-pending flag; the current handshake completes normally. cmd_abort in IDLE is ignored.
- Timeout:
  - A phase counter clears on every state entry and increments each cycle in REQ/REL.
  - Reaching TO_CYC moves to ERR, sets err_timeout, and forces step=0.
- ERR: stays until clr_err; then goes to IDLE only once step_ack=0, otherwise remains. step_count is held.
- done_seen clears when the next command is accepted.
- An asynchronous reset mid-handshake returns to IDLE with step=0 immediately.

Optional Feature:
- Macro STEP_CTRL_PERF_EN.
- Defined: adds output ack_lat_max [TO_W-1:0], the largest REQ-phase cycle count seen; it resets to 0 and clears on clr_err.
- Undefined: no port and no logic.

Decomposition:
- Package step_ctrl_pkg holds:
  - state enum (IDLE, REQ, REL, ERR)
  - default TO_CYC constant
  - a shared handshake-phase typedef, reused by bench models
- Sub-module step_phase_timer holds the clearable saturating counter with a terminal flag. It is instantiated once.

Test Plan:
1. Immediate-ack core model, cmd_single -> step high for exactly one REQ phase; step_count=1; burst_done pulses once; 4-cycle step period.
2. cmd_burst with burst_len=256 against an ack model delayed 3 cycles -> step_count=256, a single burst_done pulse, done_seen=0.
3. burst_len=1000, core_done raised after step 150 -> burst ends with step_count=150 or 151, done_seen=1.
4. cmd_abort during REQ of step 10 of 50 -> step 10 completes, step_count=10, IDLE.
5. Ack model never responds, TO_CYC=20 -> ERR after 20 REQ cycles, err_timeout=1, step=0; clr_err with ack=0 -> IDLE.
6. Assert rst_n low while in REL -> all outputs 0 asynchronously; burst_len=0 afterwards gives a burst_done pulse with no step.
